sincos_poly_iter: RTL and testbench

- Parametrised, handshaked successor to the combinational polynomial sine block.
- Computes sin or cos of a full-circle unsigned phase with an odd 7th-order polynomial. Horner evaluation is time-multiplexed over one multiplier under an FSM.
- Sits between the phase accumulator and the qubit-drive amplitude path. A tag field identifies the requesting channel.

---
 rtl/sincos_poly_pkg.sv | 27 ++
 rtl/sincos_fixmul.sv | 17 +
 rtl/sincos_poly_iter.sv | 179 +++++++++++++++++
 tb/tb_sincos_poly_iter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sincos_poly_pkg.sv
// Shared types and constants for the iterative polynomial sine/cosine block.
//   state_e        : FSM state encoding for sincos_poly_iter
//   C*_R / coef_q  : Taylor coefficients of sin(pi*x/2) and their fixed-point quantiser
//   fold_quadrant  : maps the in-quadrant offset onto the rising quarter-wave
package sincos_poly_pkg;

    typedef enum logic [2:0] {StIdle, StSquare, StHorner, StFinal, StOut} state_e;

    localparam real C1_R = 1.5707963;
    localparam real C3_R = -0.6459641;
    localparam real C5_R = 0.0796926;
    localparam real C7_R = -0.0046817;

    // Real-to-int cast rounds to nearest.
    function automatic int coef_q(input real c, input int unsigned frac_w);
        return int'(c * (2.0 ** frac_w));
    endfunction

    // Odd quadrants run the quarter-wave backwards: u = quarter - r.
    function automatic logic [31:0] fold_quadrant(input logic [31:0] r, input logic odd,
                                                  input int unsigned r_w);
        logic [31:0] quarter;
        quarter = 32'd1 << r_w;
        return odd ? (quarter - r) : r;
    endfunction

endpackage

// File: rtl/sincos_fixmul.sv
// Signed fixed-point multiplier shared by every FSM step.
//   a_i, b_i : Q2.(COEF_W-2) operands
//   p_o      : Q2.(COEF_W-2) product, truncated (floor) after realignment
module sincos_fixmul #(
    parameter int unsigned COEF_W = 18
) (
    input  logic signed [COEF_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [COEF_W-1:0] p_o
);

    logic signed [2*COEF_W-1:0] full;

    assign full = a_i * b_i;
    assign p_o  = COEF_W'(full >>> (COEF_W - 2));

endmodule

// File: rtl/sincos_poly_iter.sv
// Handshaked sin/cos of a full-circle unsigned phase using a 7th-order odd polynomial,
// evaluated by Horner's rule over a single shared multiplier.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    : request handshake; in_phase, in_cos (1 = cosine), in_tag
//   out_valid/out_ready  : result handshake; out_value (signed Q1.(OUT_W-1)), out_tag
module sincos_poly_iter
    import sincos_poly_pkg::*;
#(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned COEF_W  = 18,
    parameter int unsigned TAG_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PHASE_W-1:0] in_phase,
    input  logic               in_cos,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_value,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int unsigned FRAC_W    = COEF_W - 2;
    localparam int unsigned U_W       = PHASE_W - 1;
    localparam int unsigned U_SHIFT   = FRAC_W - (PHASE_W - 2);
    localparam int unsigned RND_SHIFT = FRAC_W - (OUT_W - 1);

    localparam logic [PHASE_W-1:0] QUARTER_P = {2'b01, {(PHASE_W - 2){1'b0}}};

    localparam logic signed [COEF_W-1:0] C1 = COEF_W'(coef_q(C1_R, FRAC_W));
    localparam logic signed [COEF_W-1:0] C3 = COEF_W'(coef_q(C3_R, FRAC_W));
    localparam logic signed [COEF_W-1:0] C5 = COEF_W'(coef_q(C5_R, FRAC_W));
    localparam logic signed [COEF_W-1:0] C7 = COEF_W'(coef_q(C7_R, FRAC_W));

    localparam logic signed [COEF_W:0]  RND_HALF    = {{COEF_W{1'b0}}, 1'b1} << (RND_SHIFT - 1);
    localparam logic signed [COEF_W:0]  OUT_MAX_EXT = {{(COEF_W + 2 - OUT_W){1'b0}},
                                                       {(OUT_W - 1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX     = {1'b0, {(OUT_W - 1){1'b1}}};

    state_e                     state_q;
    logic [1:0]                 cnt_q;
    logic signed [COEF_W-1:0]   u_q, s_q, acc_q, y_q;
    logic                       neg_q;
    logic [TAG_W-1:0]           tag_q;
    logic                       out_valid_q;
    logic [OUT_W-1:0]           out_value_q;
    logic [TAG_W-1:0]           out_tag_q;

    logic                       accept;
    logic [PHASE_W-1:0]         p_full;
    logic [1:0]                 p_q;
    logic [PHASE_W-3:0]         p_r;
    logic [U_W-1:0]             u_fold;
    logic signed [COEF_W-1:0]   u_coef;
    logic signed [COEF_W-1:0]   mul_a, mul_b, mul_p, horner_c;
    logic signed [COEF_W:0]     y_ext, y_rnd;
    logic signed [OUT_W-1:0]    mag, res;

    assign in_ready = (state_q == StIdle) || ((state_q == StOut) && out_ready);
    assign accept   = in_valid && in_ready;

    // Cosine is sine advanced by a quarter turn; the add wraps modulo the full circle.
    assign p_full = in_cos ? (in_phase + QUARTER_P) : in_phase;
    assign p_q    = p_full[PHASE_W-1 -: 2];
    assign p_r    = p_full[PHASE_W-3:0];
    assign u_fold = U_W'(fold_quadrant(32'(p_r), p_q[0], PHASE_W - 2));
    assign u_coef = $signed(COEF_W'(u_fold) << U_SHIFT);

    always_comb begin
        mul_a = acc_q;
        mul_b = u_q;
        case (state_q)
            StSquare: begin
                mul_a = u_q;
                mul_b = u_q;
            end
            StHorner: begin
                mul_a = acc_q;
                mul_b = s_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        horner_c = C1;
        case (cnt_q)
            2'd0:    horner_c = C5;
            2'd1:    horner_c = C3;
            default: horner_c = C1;
        endcase
    end

    sincos_fixmul #(
        .COEF_W (COEF_W)
    ) u_fixmul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (mul_p)
    );

    // Round half up from Q2.FRAC_W to Q1.(OUT_W-1); saturate before applying the sign
    // so the most negative code can never be produced.
    assign y_ext = {y_q[COEF_W-1], y_q};
    assign y_rnd = (y_ext + RND_HALF) >>> RND_SHIFT;
    assign mag   = (y_rnd > OUT_MAX_EXT) ? OUT_MAX : y_rnd[OUT_W-1:0];
    assign res   = neg_q ? -mag : mag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            u_q         <= '0;
            s_q         <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            neg_q       <= 1'b0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_tag_q   <= '0;
        end else begin
            case (state_q)
                StSquare: begin
                    s_q     <= mul_p;
                    acc_q   <= C7;
                    cnt_q   <= 2'd0;
                    state_q <= StHorner;
                end
                StHorner: begin
                    acc_q <= horner_c + mul_p;
                    if (cnt_q == 2'd2) begin
                        cnt_q   <= 2'd0;
                        state_q <= StFinal;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                // Two cycles: the final product is registered before rounding and
                // negation so the multiplier never chains into the output adders.
                StFinal: begin
                    if (cnt_q == 2'd0) begin
                        y_q   <= mul_p;
                        cnt_q <= 2'd1;
                    end else begin
                        out_value_q <= res;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        cnt_q       <= 2'd0;
                        state_q     <= StOut;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: ;
            endcase
            // Acceptance overrides the OUT exit so a handoff request starts at once.
            if (accept) begin
                u_q     <= u_coef;
                neg_q   <= p_q[1];
                tag_q   <= in_tag;
                state_q <= StSquare;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_sincos_poly_iter.sv
// Scoreboard bench for sincos_poly_iter: the driver pushes real-valued expectations on
// acceptance, an independent monitor pops and compares whenever a result is handed off.
module tb_sincos_poly_iter;

    localparam int unsigned PHASE_W = 16;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned COEF_W  = 18;
    localparam int unsigned TAG_W   = 4;
    localparam int          LATENCY = 6;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PHASE_W-1:0] in_phase = '0;
    logic               in_cos = 1'b0;
    logic [TAG_W-1:0]   in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [OUT_W-1:0]   out_value;
    logic [TAG_W-1:0]   out_tag;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        int  tag;
        int  phase;
        bit  is_cos;
        real exp_val;
        bit  exact_zero;
        int  acc_edge;
    } exp_t;

    exp_t sb[$];
    int   out_edges[$];
    int   sin_seen[int];
    int   last_acc_edge = 0;
    int   last_pop_edge = -1;

    sincos_poly_iter #(
        .PHASE_W (PHASE_W),
        .OUT_W   (OUT_W),
        .COEF_W  (COEF_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_phase  (in_phase),
        .in_cos    (in_cos),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_tag   (out_tag)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

    task automatic check(input string name, input bit ok, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic real poly(input real x);
        real x2;
        x2 = x * x;
        return x * (1.5707963 + x2 * (-0.6459641 + x2 * (0.0796926 + x2 * (-0.0046817))));
    endfunction

    // Reference: the specified polynomial in real arithmetic, phase folded in
    // quarter-turn units. Note the Taylor polynomial itself tops out near 32763.
    function automatic void model(input int phase, input bit is_cos, output real v,
                                  output bit zero);
        int  pa;
        real t;
        bit  neg;
        pa  = is_cos ? (phase + 16384) % 65536 : phase;
        t   = pa / 16384.0;
        neg = (t >= 2.0);
        if (neg) t = t - 2.0;
        if (t > 1.0) t = 2.0 - t;
        zero = (t == 0.0);
        v = poly(t) * 32768.0;
        if (v > 32767.0) v = 32767.0;
        if (neg) v = -v;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting edge
    // with in_valid still high so the caller can chain another request.
    task automatic send(input int phase, input bit is_cos, input int tag);
        exp_t e;
        real  v;
        bit   z;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_phase = PHASE_W'(phase);
        in_cos   = is_cos;
        in_tag   = TAG_W'(tag);
        for (int i = 0; i < 100 && !done; i++) begin
            #2;
            if (in_ready) begin
                model(phase, is_cos, v, z);
                e.tag        = tag & ((1 << TAG_W) - 1);
                e.phase      = phase;
                e.is_cos     = is_cos;
                e.exp_val    = v;
                e.exact_zero = z;
                e.acc_edge   = cyc + 1;
                sb.push_back(e);
                last_acc_edge = cyc + 1;
                done = 1'b1;
            end
            @(negedge clock);
        end
        if (!done) begin
            check("accept_timeout", 1'b0, 0, 1);
            in_valid = 1'b0;
        end
    endtask

    // Inputs are scrambled while idle to show latched requests ignore later changes.
    task automatic idle(input int n);
        in_valid = 1'b0;
        in_phase = PHASE_W'($urandom);
        in_cos   = 1'($urandom_range(0, 1));
        in_tag   = TAG_W'($urandom);
        repeat (n) @(negedge clock);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() != 0 && i < 400) begin
            @(negedge clock);
            i++;
        end
        check("drain", sb.size() == 0, sb.size(), 0);
    endtask

    initial begin : monitor
        exp_t             e;
        int               got;
        real              diff;
        int               nph;
        bit               seen;
        bit               holding;
        logic [OUT_W-1:0] hv;
        logic [TAG_W-1:0] ht;
        seen    = 1'b0;
        holding = 1'b0;
        hv      = '0;
        ht      = '0;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                seen    = 1'b0;
                holding = 1'b0;
            end else begin
                if (holding) begin
                    check("hold_valid", out_valid == 1'b1, int'(out_valid), 1);
                    check("hold_value", out_value == hv, int'(out_value), int'(hv));
                    check("hold_tag", out_tag == ht, int'(out_tag), int'(ht));
                end
                if (!out_valid) begin
                    holding = 1'b0;
                end else if (sb.size() == 0) begin
                    check("unexpected_out", 1'b0, 1, 0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        out_edges.push_back(cyc);
                        check("latency", cyc - sb[0].acc_edge == LATENCY,
                              cyc - sb[0].acc_edge, LATENCY);
                    end
                    if (out_ready) begin
                        e   = sb.pop_front();
                        got = int'($signed(out_value));
                        check("tag", int'(out_tag) == e.tag, int'(out_tag), e.tag);
                        if (e.exact_zero) begin
                            check("value_zero", got == 0, got, 0);
                        end else begin
                            diff = $itor(got) - e.exp_val;
                            if (e.is_cos)
                                check("cos_value", diff <= 3.0 && diff >= -3.0, got,
                                      $rtoi(e.exp_val));
                            else
                                check("sin_value", diff <= 3.0 && diff >= -3.0, got,
                                      $rtoi(e.exp_val));
                        end
                        check("no_min_code", got != -32768, got, -32767);
                        if (!e.is_cos) begin
                            nph = (65536 - e.phase) % 65536;
                            if (sin_seen.exists(nph))
                                check("odd_symmetry", got == -sin_seen[nph], got,
                                      -sin_seen[nph]);
                            sin_seen[e.phase] = got;
                        end
                        last_pop_edge = cyc + 1;
                        seen    = 1'b0;
                        holding = 1'b0;
                    end else begin
                        holding = 1'b1;
                        hv      = out_value;
                        ht      = out_tag;
                        check("stall_in_ready", in_ready == 1'b0, int'(in_ready), 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        int sin_ph[5];
        int cos_ph[4];
        int x;
        sin_ph = '{0, 8192, 16384, 32768, 49152};
        cos_ph = '{0, 16384, 32768, 65535};

        // Reset state
        #12;
        check("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check("rst_out_value", out_value == '0, int'(out_value), 0);
        check("rst_out_tag", out_tag == '0, int'(out_tag), 0);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("rst_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        @(negedge clock);

        // Directed sine and cosine points
        foreach (sin_ph[i]) begin
            send(sin_ph[i], 1'b0, i);
            idle(0);
            drain();
        end
        foreach (cos_ph[i]) begin
            send(cos_ph[i], 1'b1, 8 + i);
            idle(0);
            drain();
        end

        // Reset during HORNER drops the request
        send(1234, 1'b0, 5);
        idle(1);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("midrst_in_ready", in_ready == 1'b1, int'(in_ready), 1);
        @(negedge clock);
        idle(12);

        // Reset while a result is stalled clears out_valid asynchronously
        out_ready = 1'b0;
        send(5000, 1'b0, 6);
        idle(7);
        #3;
        check("stall_pre_reset", out_valid == 1'b1, int'(out_valid), 1);
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check("async_out_value", out_value == '0, int'(out_value), 0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        idle(12);

        // Back-to-back stream: accept on the handoff edge gives one result per LATENCY+1
        out_edges.delete();
        for (int t = 0; t < 16; t++) send(int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), t);
        idle(0);
        drain();
        check("stream_count", out_edges.size() == 16, out_edges.size(), 16);
        for (int i = 1; i < out_edges.size(); i++)
            check("stream_spacing", out_edges[i] - out_edges[i-1] == LATENCY + 1,
                  out_edges[i] - out_edges[i-1], LATENCY + 1);

        // Output stall for 10 cycles with a competing request, then same-edge handoff
        out_ready = 1'b0;
        send(20000, 1'b0, 9);
        idle(7);
        in_valid = 1'b1;
        in_phase = PHASE_W'(3000);
        in_cos   = 1'b1;
        in_tag   = TAG_W'(10);
        repeat (10) @(negedge clock);
        out_ready = 1'b1;
        send(3000, 1'b1, 10);
        check("handoff_accept", last_acc_edge == last_pop_edge, last_acc_edge, last_pop_edge);
        idle(0);
        drain();

        // Randomised sweep with mirrored sine pairs and random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 500; i++) begin
            x = int'($urandom_range(0, 65535));
            send(x, 1'b0, i);
            idle(int'($urandom_range(0, 2)));
            send((65536 - x) % 65536, 1'b0, i + 1);
            idle(int'($urandom_range(0, 2)));
            send(int'($urandom_range(0, 65535)), 1'b1, i + 2);
            idle(int'($urandom_range(0, 2)));
        end
        drain();
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
